pulse_domain_receiver: RTL and testbench

Receive end of the toggle-encoded event crossing used between the wavegen clock domains. An asynchronous request toggle from a foreign domain is synchronised into `clock`. Each transition is counted as one event and replayed as single-cycle `pulseOut` strobes, with downstream backpressure honoured. An acknowledge toggle is returned so the sender can tell when each event has been taken.

---
 rtl/pulse_domain_receiver.sv | 110 +++++++++++
 tb/tb_pulse_domain_receiver.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_domain_receiver.sv
// pulse_domain_receiver
//
// Receive side of a toggle-encoded event crossing. Each level change on the
// asynchronous request toggle reqIn is one event. reqIn is synchronised into
// clock and each event is counted. Events are then replayed as single-cycle
// strobes on pulseOut while honouring downstream backpressure. An acknowledge
// toggle is returned to the sender.
//
// Parameters:
//   SYNC_STAGES    synchroniser depth on reqIn (>= 2)
//   PENDING_WIDTH  width of the pending-event counter
//
// Ports:
//   clock          sole clock
//   reset          asynchronous, active-low reset
//   reqIn          asynchronous request toggle; every level change is an event
//   pulseReady     downstream may accept a pulse this cycle
//   clearOverflow  synchronous clear of overflow
//   pulseOut       registered one-cycle event strobe
//   ackOut         registered acknowledge toggle (last synchronised request)
//   pending        events received but not yet issued
//   overflow       sticky flag: an event was dropped because pending was full
module pulse_domain_receiver #(
   parameter int SYNC_STAGES   = 2,
   parameter int PENDING_WIDTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     reqIn,
   input  logic                     pulseReady,
   input  logic                     clearOverflow,
   output logic                     pulseOut,
   output logic                     ackOut,
   output logic [PENDING_WIDTH-1:0] pending,
   output logic                     overflow
);

   localparam logic [PENDING_WIDTH-1:0] PENDING_MAX = '1;
   localparam logic [PENDING_WIDTH-1:0] PENDING_ONE = PENDING_WIDTH'(1);

   logic [SYNC_STAGES-1:0]   sync_reg;
   logic                     sync_last_reg;
   logic                     pulse_reg;
   logic [PENDING_WIDTH-1:0] pending_reg;
   logic [PENDING_WIDTH-1:0] pending_next;
   logic                     overflow_reg;
   logic                     overflow_next;
   logic                     event_hit;
   logic                     fire;
   logic                     overflow_set;

   // Synchroniser chain plus one extra stage. The extra stage is the
   // acknowledge toggle and the reference for edge detection.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_reg      <= '0;
         sync_last_reg <= 1'b0;
      end else begin
         sync_reg      <= {sync_reg[SYNC_STAGES-2:0], reqIn};
         sync_last_reg <= sync_reg[SYNC_STAGES-1];
      end
   end

   assign event_hit = sync_reg[SYNC_STAGES-1] ^ sync_last_reg;

   // A pulse may not issue while the previous one is still high.
   // This forces at least one low cycle between strobes.
   assign fire = pulseReady && !pulse_reg && (pending_reg != '0);

   always_comb begin
      pending_next = pending_reg;
      overflow_set = 1'b0;
      if (event_hit && !fire) begin
         if (pending_reg == PENDING_MAX) begin
            overflow_set = 1'b1;
         end else begin
            pending_next = pending_reg + PENDING_ONE;
         end
      end else if (!event_hit && fire) begin
         pending_next = pending_reg - PENDING_ONE;
      end
      // A drop in the same cycle as a clear keeps the flag set.
      // Otherwise the dropped event would go unreported.
      if (overflow_set) begin
         overflow_next = 1'b1;
      end else if (clearOverflow) begin
         overflow_next = 1'b0;
      end else begin
         overflow_next = overflow_reg;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pulse_reg    <= 1'b0;
         pending_reg  <= '0;
         overflow_reg <= 1'b0;
      end else begin
         pulse_reg    <= fire;
         pending_reg  <= pending_next;
         overflow_reg <= overflow_next;
      end
   end

   assign pulseOut = pulse_reg;
   assign ackOut   = sync_last_reg;
   assign pending  = pending_reg;
   assign overflow = overflow_reg;

endmodule

// File: tb/tb_pulse_domain_receiver.sv
// tb_pulse_domain_receiver
//
// Directed bench for pulse_domain_receiver (SYNC_STAGES=2, PENDING_WIDTH=2).
// A behavioural model describes the expected outputs in terms of the reqIn
// sample history and an event count. A compare process checks every output
// against this model on each falling edge. Directed sequences add literal
// expectations for the spec timing: single event, burst, backpressure with
// overflow, clear priority, coincident event/fire at max, and reset
// mid-operation.
module tb_pulse_domain_receiver;

   localparam int S    = 2;
   localparam int PW   = 2;
   localparam int MAXP = (1 << PW) - 1;

   logic          clock;
   logic          reset;
   logic          reqIn;
   logic          pulseReady;
   logic          clearOverflow;
   logic          pulseOut;
   logic          ackOut;
   logic [PW-1:0] pending;
   logic          overflow;

   int vectors    = 0;
   int miscompares = 0;

   pulse_domain_receiver #(
      .SYNC_STAGES  (S),
      .PENDING_WIDTH(PW)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .reqIn        (reqIn),
      .pulseReady   (pulseReady),
      .clearOverflow(clearOverflow),
      .pulseOut     (pulseOut),
      .ackOut       (ackOut),
      .pending      (pending),
      .overflow     (overflow)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // hist[i] is the reqIn value sampled i edges ago.
   // An event becomes visible once a change has aged S edges. The
   // acknowledge shows the sample that is S edges old.
   logic hist [0:S];
   int   m_pending  = 0;
   logic m_overflow = 1'b0;
   logic m_pulse    = 1'b0;
   logic m_event;
   logic m_fire;
   int   m_sum;

   initial begin
      for (int i = 0; i <= S; i++) hist[i] = 1'b0;
   end

   always_comb begin
      m_event = hist[S-1] ^ hist[S];
      m_fire  = pulseReady && !m_pulse && (m_pending > 0);
      m_sum   = m_pending + (m_event ? 1 : 0) - (m_fire ? 1 : 0);
   end

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i <= S; i++) hist[i] <= 1'b0;
         m_pending  <= 0;
         m_overflow <= 1'b0;
         m_pulse    <= 1'b0;
      end else begin
         hist[0] <= reqIn;
         for (int i = 1; i <= S; i++) hist[i] <= hist[i-1];
         m_pulse <= m_fire;
         if (m_sum > MAXP) begin
            m_pending  <= MAXP;
            m_overflow <= 1'b1;
         end else begin
            m_pending  <= m_sum;
            m_overflow <= clearOverflow ? 1'b0 : m_overflow;
         end
      end
   end

   // ---------------- compare / monitor process ----------------
   logic cmp_on = 1'b0;
   logic prev_pulse = 1'b0;
   int   pulse_cnt = 0;
   int   peak = 0;

   always @(negedge clock) begin
      if (cmp_on) begin
         check("pulseOut", {31'd0, pulseOut}, {31'd0, m_pulse});
         check("ackOut", {31'd0, ackOut}, {31'd0, hist[S]});
         check("pending", {30'd0, pending}, m_pending);
         check("overflow", {31'd0, overflow}, {31'd0, m_overflow});
         check("pulse_spacing", {31'd0, pulseOut & prev_pulse}, 32'd0);
         if (pulseOut === 1'b1) pulse_cnt++;
         if (int'(pending) > peak) peak = int'(pending);
         prev_pulse = pulseOut;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_pulseOut"}, {31'd0, pulseOut}, 32'd0);
      check({tag, "_ackOut"}, {31'd0, ackOut}, 32'd0);
      check({tag, "_pending"}, {30'd0, pending}, 32'd0);
      check({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
   endtask

   // Asserts reset between clock edges and checks that outputs clear at once.
   // Inputs are parked while reset is low, then reset is released.
   task automatic mid_reset(input string tag);
      #2 reset = 1'b0;
      #1 check_all_zero(tag);
      reqIn = 1'b0;
      pulseReady = 1'b0;
      clearOverflow = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      repeat (3) tick();
   endtask

   task automatic toggle_spaced(input int n);
      for (int k = 0; k < n; k++) begin
         reqIn = ~reqIn;
         repeat (3) tick();
      end
   endtask

   int base;

   initial begin
      reset = 1'b0;
      reqIn = 1'b0;
      pulseReady = 1'b0;
      clearOverflow = 1'b0;
      tick();
      cmp_on = 1'b1;
      repeat (2) tick();
      check_all_zero("reset");
      reset = 1'b1;
      repeat (5) tick();

      // Single event: capture at edge E. Ack and pending follow at E+2, the
      // pulse at E+3.
      base = pulse_cnt;
      pulseReady = 1'b1;
      reqIn = 1'b1;
      tick();                                    // edge E: captured
      tick();                                    // E+1
      check("single_ack_e1", {31'd0, ackOut}, 32'd0);
      check("single_pend_e1", {30'd0, pending}, 32'd0);
      tick();                                    // E+2
      check("single_ack_e2", {31'd0, ackOut}, 32'd1);
      check("single_pend_e2", {30'd0, pending}, 32'd1);
      check("single_pulse_e2", {31'd0, pulseOut}, 32'd0);
      tick();                                    // E+3
      check("single_pulse_e3", {31'd0, pulseOut}, 32'd1);
      check("single_pend_e3", {30'd0, pending}, 32'd0);
      tick();                                    // E+4
      check("single_pulse_e4", {31'd0, pulseOut}, 32'd0);
      repeat (5) tick();
      check("single_count", pulse_cnt - base, 32'd1);

      // Burst: three toggles on consecutive edges.
      mid_reset("rst_b");
      base = pulse_cnt;
      peak = 0;
      pulseReady = 1'b1;
      reqIn = 1'b1; tick();
      reqIn = 1'b0; tick();
      reqIn = 1'b1; tick();
      repeat (15) tick();
      check("burst_count", pulse_cnt - base, 32'd3);
      check("burst_peak", peak, 32'd2);
      check("burst_pend", {30'd0, pending}, 32'd0);
      check("burst_ack", {31'd0, ackOut}, 32'd1);

      // Backpressure: five toggles with pulseReady low. The 4th event overflows.
      mid_reset("rst_c");
      pulseReady = 1'b0;
      toggle_spaced(3);
      check("bp_pend3", {30'd0, pending}, 32'd3);
      check("bp_ovf3", {31'd0, overflow}, 32'd0);
      toggle_spaced(1);
      check("bp_pend4", {30'd0, pending}, 32'd3);
      check("bp_ovf4", {31'd0, overflow}, 32'd1);
      toggle_spaced(1);
      base = pulse_cnt;
      pulseReady = 1'b1;
      repeat (10) tick();
      check("bp_count", pulse_cnt - base, 32'd3);
      check("bp_pend_end", {30'd0, pending}, 32'd0);
      check("bp_ovf_end", {31'd0, overflow}, 32'd1);
      check("bp_ack", {31'd0, ackOut}, 32'd1);

      // Clear priority: a drop coinciding with clearOverflow keeps the flag set.
      pulseReady = 1'b0;
      toggle_spaced(3);
      check("clr_pend", {30'd0, pending}, 32'd3);
      reqIn = ~reqIn;
      tick();                                    // captured
      tick();
      clearOverflow = 1'b1;
      tick();                                    // event and clear together
      check("clr_ovf_kept", {31'd0, overflow}, 32'd1);
      check("clr_pend_held", {30'd0, pending}, 32'd3);
      tick();                                    // clear alone
      check("clr_ovf_cleared", {31'd0, overflow}, 32'd0);
      clearOverflow = 1'b0;
      tick();

      // Event in the same cycle as a fire at max: no overflow, pending holds.
      reqIn = ~reqIn;
      tick();                                    // captured
      tick();
      pulseReady = 1'b1;
      tick();                                    // fire and event together
      check("coin_pend", {30'd0, pending}, 32'd3);
      check("coin_ovf", {31'd0, overflow}, 32'd0);
      check("coin_pulse", {31'd0, pulseOut}, 32'd1);
      repeat (12) tick();
      check("coin_drain", {30'd0, pending}, 32'd0);

      // Reset mid-operation while a pulse is high and two events are pending.
      pulseReady = 1'b0;
      reqIn = 1'b0;
      repeat (4) tick();
      toggle_spaced(3);
      pulseReady = 1'b1;
      tick();
      check("mid_pulse", {31'd0, pulseOut}, 32'd1);
      check("mid_pend", {30'd0, pending}, 32'd2);
      pulseReady = 1'b1;
      #2 reset = 1'b0;
      #1 check_all_zero("mid_rst");
      reqIn = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      base = pulse_cnt;
      repeat (10) tick();
      check("mid_no_pulse", pulse_cnt - base, 32'd0);
      check("mid_pend_after", {30'd0, pending}, 32'd0);
      check("mid_ack_after", {31'd0, ackOut}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
